// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single memory port.
// Round-robin grant, mov/moc handshake with return-to-zero release and access timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        mem_moc,
    input  logic [31:0] mem_rdata,
    output logic        mem_mov,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        if_done,
    output logic        d_done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_last_d;
    logic       r_own_d;
    logic [7:0] r_count;
    logic       w_grant;
    logic       w_grant_d;
    logic       w_expired;

    // On a tie the requester that did not win last time is granted.
    assign w_grant   = (r_state == S_IDLE) && (if_req || d_req);
    assign w_grant_d = d_req && (!if_req || !r_last_d);
    assign w_expired = (r_count == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_grant) w_state_next = S_ACCESS;
            S_ACCESS:  if (mem_moc || w_expired) w_state_next = S_RELEASE;
            S_RELEASE: if (!mem_moc) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_mov = (r_state == S_ACCESS);
        busy    = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d  <= 1'b1;
            r_own_d   <= 1'b0;
            r_count   <= 8'd0;
            mem_rw    <= 1'b1;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rdata     <= 32'd0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            if (w_grant) begin
                r_own_d   <= w_grant_d;
                r_last_d  <= w_grant_d;
                r_count   <= 8'd0;
                mem_addr  <= w_grant_d ? d_addr : if_addr;
                mem_rw    <= w_grant_d ? d_rw : 1'b1;
                mem_wdata <= w_grant_d ? d_wdata : 32'd0;
            end
            if (r_state == S_ACCESS) begin
                // A completion in the very cycle the count expires still wins.
                if (mem_moc) begin
                    if_done <= !r_own_d;
                    d_done  <= r_own_d;
                    rdata   <= mem_rw ? mem_rdata : 32'd0;
                end else if (w_expired) begin
                    if_done <= !r_own_d;
                    d_done  <= r_own_d;
                    err     <= 1'b1;
                    rdata   <= 32'd0;
                end else begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// tie / reset / release sequences, and random transactions against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int TMO = 15;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_moc;
    logic [31:0] mem_rdata;
    logic        mem_mov;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        if_done;
    logic        d_done;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    mem_port_arbiter #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .d_req     (d_req),
        .d_rw      (d_rw),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .mem_moc   (mem_moc),
        .mem_rdata (mem_rdata),
        .mem_mov   (mem_mov),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .if_done   (if_done),
        .d_done    (d_done),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fall = -1;
    int txn_no   = 0;
    logic model_last_d = 1'b1;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        if_req;
        logic        d_req;
        logic        d_rw;
        logic [31:0] if_addr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] rd;
        int          k;
        int          hold;
        logic        keep;
        logic        scramble;
        logic        exp_d;
        logic        exp_rw;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_len;
    } txn_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("done_overlap", 32'(if_done && d_done), 32'd0);
            chk("err_without_done", 32'(err && !(if_done || d_done)), 32'd0);
        end
    end

    function automatic txn_t mk(input logic ir, input logic dr, input logic drw,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] dw, input logic [31:0] rd,
                                input int k, input int hold,
                                input logic ed, input logic erw, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [31:0] erd,
                                input logic eerr, input int elen);
        txn_t t;
        t.if_req = ir;  t.d_req = dr;  t.d_rw = drw;
        t.if_addr = ia; t.d_addr = da; t.d_wdata = dw; t.rd = rd;
        t.k = k; t.hold = hold; t.keep = 1'b0; t.scramble = 1'b0;
        t.exp_d = ed; t.exp_rw = erw; t.exp_addr = ea; t.exp_wdata = ewd;
        t.exp_rdata = erd; t.exp_err = eerr; t.exp_len = elen;
        return t;
    endfunction

    // Reference model: decides owner and outcome from the request pattern and memory delay.
    function automatic txn_t model(input txn_t t);
        txn_t o;
        logic timed_out;
        o = t;
        if (t.if_req && t.d_req) o.exp_d = !model_last_d;
        else                     o.exp_d = t.d_req;
        o.exp_addr  = o.exp_d ? t.d_addr : t.if_addr;
        o.exp_rw    = o.exp_d ? t.d_rw : 1'b1;
        o.exp_wdata = o.exp_d ? t.d_wdata : 32'd0;
        timed_out   = (t.k > TMO);
        o.exp_err   = timed_out;
        o.exp_len   = (timed_out ? TMO : t.k) + 1;
        o.exp_rdata = (timed_out || !o.exp_rw) ? 32'd0 : t.rd;
        return o;
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_rw = 1'b0; mem_moc = 1'b0;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0;
        tick;
        tick;
        reset = 1'b0;
        model_last_d = 1'b1;
        last_fall = -1;
    endtask

    task automatic run_txn(input txn_t t);
        int   len;
        int   rise;
        logic chk_wd;
        chk_wd = !t.exp_d || !t.exp_rw;
        if_req = t.if_req; d_req = t.d_req; d_rw = t.d_rw;
        if_addr = t.if_addr; d_addr = t.d_addr; d_wdata = t.d_wdata;
        mem_moc = 1'b0; mem_rdata = t.rd;
        tick;
        rise = cyc;
        chk("grant_mov", 32'(mem_mov), 32'd1);
        chk("grant_busy", 32'(busy), 32'd1);
        if (last_fall >= 0) chk("idle_gap", 32'(rise - last_fall >= 1), 32'd1);
        len = 0;
        while (mem_mov === 1'b1 && len < 300) begin
            len++;
            chk("access_addr", mem_addr, t.exp_addr);
            chk("access_rw", 32'(mem_rw), 32'(t.exp_rw));
            if (chk_wd) chk("access_wdata", mem_wdata, t.exp_wdata);
            chk("access_no_done", 32'(if_done || d_done), 32'd0);
            if (t.scramble) begin
                if_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
                d_rw = 1'($urandom_range(0, 1));
                if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            end
            mem_moc = (len > t.k);
            tick;
        end
        last_fall = cyc;
        chk("mov_length", 32'(len), 32'(t.exp_len));
        chk("if_done", 32'(if_done), 32'(!t.exp_d));
        chk("d_done", 32'(d_done), 32'(t.exp_d));
        chk("err", 32'(err), 32'(t.exp_err));
        chk("rdata", rdata, t.exp_rdata);
        chk("release_busy", 32'(busy), 32'd1);
        chk("release_mov", 32'(mem_mov), 32'd0);
        $display("txn %0d: owner=%s rw=%0b addr=0x%08h len=%0d err=%0b rdata=0x%08h",
                 txn_no, t.exp_d ? "D" : "IF", t.exp_rw, t.exp_addr, len, err, rdata);
        txn_no++;
        model_last_d = t.exp_d;
        if (!t.keep) begin
            if_req = 1'b0;
            d_req  = 1'b0;
        end
        for (int i = 0; i < t.hold; i++) begin
            mem_moc = 1'b1;
            tick;
            chk("hold_mov", 32'(mem_mov), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_no_done", 32'(if_done || d_done), 32'd0);
        end
        mem_moc = 1'b0;
        tick;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_mov", 32'(mem_mov), 32'd0);
        chk("idle_no_done", 32'(if_done || d_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    txn_t vec [9];
    txn_t t;

    initial begin
        vec[0] = mk(1, 0, 1, 32'h10,  32'h0,   32'h0,        32'h8C220004, 2,   0, 0, 1, 32'h10,  32'h0,        32'h8C220004, 0, 3);
        vec[1] = mk(0, 1, 0, 32'h0,   32'h40,  32'hDEADBEEF, 32'h12345678, 1,   0, 1, 0, 32'h40,  32'hDEADBEEF, 32'h0,        0, 2);
        vec[2] = mk(0, 1, 1, 32'h0,   32'h80,  32'h77,       32'hA5A50001, 0,   1, 1, 1, 32'h80,  32'h0,        32'hA5A50001, 0, 1);
        vec[3] = mk(1, 1, 0, 32'h100, 32'h200, 32'h1,        32'h0BADF00D, 3,   0, 0, 1, 32'h100, 32'h0,        32'h0BADF00D, 0, 4);
        vec[4] = mk(1, 1, 0, 32'h104, 32'h204, 32'hCAFEF00D, 32'h55,       0,   3, 1, 0, 32'h204, 32'hCAFEF00D, 32'h0,        0, 1);
        vec[5] = mk(0, 1, 1, 32'h0,   32'h300, 32'h0,        32'hFFFFFFFF, 100, 0, 1, 1, 32'h300, 32'h0,        32'h0,        1, 16);
        vec[6] = mk(1, 0, 0, 32'h400, 32'h0,   32'h0,        32'h13579BDF, 15,  0, 0, 1, 32'h400, 32'h0,        32'h13579BDF, 0, 16);
        vec[7] = mk(1, 0, 1, 32'h404, 32'h0,   32'h0,        32'h2468ACE0, 16,  0, 0, 1, 32'h404, 32'h0,        32'h0,        1, 16);
        vec[8] = mk(1, 1, 1, 32'h500, 32'h600, 32'h9,        32'h31415926, 4,   1, 1, 1, 32'h600, 32'h9,        32'h31415926, 0, 5);

        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_rw = 1'b0; mem_moc = 1'b0;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0;
        tick;
        tick;
        chk("rst_mov", 32'(mem_mov), 32'd0);
        chk("rst_rw", 32'(mem_rw), 32'd1);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick;

        for (int i = 0; i < 9; i++) run_txn(vec[i]);

        // Both requests held throughout: IF, then D, then IF again.
        do_reset;
        t = mk(1, 1, 0, 32'h800, 32'h900, 32'h11, 32'h600DCAFE, 1, 0, 0, 1, 32'h800, 32'h0, 32'h600DCAFE, 0, 2);
        t.keep = 1'b1;
        run_txn(t);
        t = mk(1, 1, 0, 32'h800, 32'h900, 32'h11, 32'h600DCAFE, 1, 0, 1, 0, 32'h900, 32'h11, 32'h0, 0, 2);
        t.keep = 1'b1;
        run_txn(t);
        t = mk(1, 1, 0, 32'h800, 32'h900, 32'h11, 32'h600DCAFE, 1, 0, 0, 1, 32'h800, 32'h0, 32'h600DCAFE, 0, 2);
        run_txn(t);

        // Reset on the third ACCESS cycle of an IF access; the next tie must go to IF.
        if_req = 1'b1; if_addr = 32'h700; mem_moc = 1'b0;
        tick;
        chk("abort_mov1", 32'(mem_mov), 32'd1);
        tick;
        tick;
        chk("abort_mov3", 32'(mem_mov), 32'd1);
        reset = 1'b1;
        if_req = 1'b0;
        tick;
        chk("abort_mov", 32'(mem_mov), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(if_done || d_done), 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_rw", 32'(mem_rw), 32'd1);
        reset = 1'b0;
        model_last_d = 1'b1;
        last_fall = -1;
        tick;
        chk("abort_still_idle", 32'(busy), 32'd0);
        chk("abort_late_done", 32'(if_done || d_done), 32'd0);
        t = mk(1, 1, 1, 32'hA00, 32'hB00, 32'h0, 32'h0F0F0F0F, 0, 0, 0, 1, 32'hA00, 32'h0, 32'h0F0F0F0F, 0, 1);
        run_txn(t);

        for (int n = 0; n < 40; n++) begin
            t.if_req   = 1'($urandom_range(0, 1));
            t.d_req    = 1'($urandom_range(0, 1));
            if (!t.if_req && !t.d_req) t.d_req = 1'b1;
            t.d_rw     = 1'($urandom_range(0, 1));
            t.if_addr  = $urandom;
            t.d_addr   = $urandom;
            t.d_wdata  = $urandom;
            t.rd       = $urandom;
            t.k        = int'($urandom_range(0, 18));
            t.hold     = int'($urandom_range(0, 2));
            t.keep     = 1'b0;
            t.scramble = 1'($urandom_range(0, 1));
            run_txn(model(t));
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
